sram_1rw1r_sync: RTL and testbench

- Parametrised, synthesizable single-clock 1RW/1R SRAM model; next generation of the OpenRAM 32x512 1rw1r behavioural macro model.
- Used in the user project as a drop-in behavioural memory for simulation and FPGA bring-up.
- Adds over the fixed macro model: generic width/depth/byte-mask, registered read-valid strobes, same-address collision detection with selectable bypass, and an optional post-reset zero-fill engine.

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_clear_fsm.sv | 55 +++++
 rtl/sram_1rw1r_sync.sv | 135 +++++++++++++
 tb/tb_sram_1rw1r_sync.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the 1RW/1R SRAM model.
// Clear-engine states, default geometry and the byte-lane merge.
package sram_pkg;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } clr_state_e;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 9;

   // One byte lane of a masked write: new byte if its mask bit is set.
   function automatic logic [7:0] merge(
      input logic [7:0] old_b,
      input logic [7:0] new_b,
      input logic       m
   );
      return m ? new_b : old_b;
   endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// sram_clear_fsm: post-reset zero-fill engine.
// Walks every address once, then hands the array to the ports.
module sram_clear_fsm
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  busy_o,
   output logic                  clr_en_o,
   output logic [ADDR_WIDTH-1:0] clr_addr_o
);

   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST =
      CNT_W'((1 << ADDR_WIDTH) - 1);
   localparam clr_state_e RST_ST =
      CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

   clr_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State and clear counter; reset restarts the fill from zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RST_ST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: one zero write per cycle until the last address.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_en_o = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            clr_en_o = !rst_i;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) state_d = ST_READY;
         end
         ST_READY: state_d = ST_READY;
      endcase
   end

   assign busy_o     = (state_q == ST_CLEAR)
                     | (rst_i & CLEAR_ON_RESET);
   assign clr_addr_o = cnt_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/sram_1rw1r_sync.sv
// sram_1rw1r_sync: single-clock 1RW/1R behavioural SRAM.
// Registered request stage, byte-masked writes, collision bypass.
module sram_1rw1r_sync
   import sram_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int NUM_WMASKS     = DATA_WIDTH / 8,
   parameter bit BYPASS         = 1'b1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   output logic                  dout0_valid,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic                  dout1_valid,
   output logic                  collision,
   output logic                  init_busy
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  csb0_q, csb1_q, web0_q;
   logic [NUM_WMASKS-1:0] wmask0_q;
   logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
   logic [DATA_WIDTH-1:0] din0_q;

   logic                  busy, clr_en;
   logic [ADDR_WIDTH-1:0] clr_addr;

   logic                  rd0, wr0, rd1, coll_d;
   logic [DATA_WIDTH-1:0] old0_w, merged_w;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   logic [DATA_WIDTH-1:0] dout0_q, dout1_q;
   logic                  v0_q, v1_q, coll_q;

   sram_clear_fsm #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clr (
      .clk_i      (wb_clk_i),
      .rst_i      (wb_rst_i),
      .busy_o     (busy),
      .clr_en_o   (clr_en),
      .clr_addr_o (clr_addr)
   );

   // Request controls; requests are dropped while the fill runs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || busy) begin
         csb0_q <= 1'b1;
         csb1_q <= 1'b1;
         web0_q <= 1'b1;
      end else begin
         csb0_q <= csb0;
         csb1_q <= csb1;
         web0_q <= web0;
      end
   end

   // Request payload; only meaningful when a select is active.
   always_ff @(posedge wb_clk_i) begin
      wmask0_q <= wmask0;
      addr0_q  <= addr0;
      addr1_q  <= addr1;
      din0_q   <= din0;
   end

   assign rd0    = !csb0_q && web0_q;
   assign wr0    = !csb0_q && !web0_q;
   assign rd1    = !csb1_q;
   assign coll_d = wr0 && rd1 && (addr0_q == addr1_q)
                && (|wmask0_q);
   assign old0_w = mem_q[addr0_q];

   // New word for a masked write: written lanes from din0.
   always_comb begin
      merged_w = old0_w;
      for (int i = 0; i < NUM_WMASKS; i++) begin
         merged_w[8*i +: 8] = merge(old0_w[8*i +: 8],
                                    din0_q[8*i +: 8],
                                    wmask0_q[i]);
      end
   end

   assign wr_en   = clr_en || wr0;
   assign wr_addr = clr_en ? clr_addr : addr0_q;
   assign wr_data = clr_en ? '0 : merged_w;

   // Array write port, shared by the fill engine and port 0.
   always_ff @(posedge wb_clk_i) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   // Read data, valid strobes and the collision flag.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         dout0_q <= '0;
         dout1_q <= '0;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         coll_q  <= 1'b0;
      end else begin
         v0_q   <= rd0;
         v1_q   <= rd1;
         coll_q <= coll_d;
         if (rd0) dout0_q <= mem_q[addr0_q];
         if (rd1) begin
            dout1_q <= (BYPASS && coll_d) ? merged_w
                                          : mem_q[addr1_q];
         end
      end
   end

   assign dout0       = dout0_q;
   assign dout1       = dout1_q;
   assign dout0_valid = v0_q;
   assign dout1_valid = v1_q;
   assign collision   = coll_q;
   assign init_busy   = busy;

endmodule

// File: tb/tb_sram_1rw1r_sync.sv
// tb_sram_1rw1r_sync: directed bench with a transaction-level model.
// Two instances share inputs: bypass on (a) and bypass off (b).
module tb_sram_1rw1r_sync;

   localparam int DW    = 32;
   localparam int AW    = 9;
   localparam int NW    = 4;
   localparam int DEPTH = 512;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
   logic [NW-1:0] wmask0 = '0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] din0 = '0;

   logic [DW-1:0] d0_a, d1_a, d0_b, d1_b;
   logic          v0_a, v1_a, col_a, busy_a;
   logic          v0_b, v1_b, col_b, busy_b;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   sram_1rw1r_sync #(.BYPASS(1'b1)) u_a (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .csb0(csb0), .web0(web0), .wmask0(wmask0),
      .addr0(addr0), .din0(din0),
      .dout0(d0_a), .dout0_valid(v0_a),
      .csb1(csb1), .addr1(addr1),
      .dout1(d1_a), .dout1_valid(v1_a),
      .collision(col_a), .init_busy(busy_a)
   );

   sram_1rw1r_sync #(.BYPASS(1'b0)) u_b (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .csb0(csb0), .web0(web0), .wmask0(wmask0),
      .addr0(addr0), .din0(din0),
      .dout0(d0_b), .dout0_valid(v0_b),
      .csb1(csb1), .addr1(addr1),
      .dout1(d1_b), .dout1_valid(v1_b),
      .collision(col_b), .init_busy(busy_b)
   );

   task automatic chk(input string nm,
                      input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Model: memory image, busy countdown, one pending request.
   logic [DW-1:0] mmem [DEPTH];
   int            busy_cnt = 0;
   logic          p_rd0 = 0, p_wr = 0, p_rd1 = 0;
   logic [AW-1:0] p_a0 = '0, p_a1 = '0;
   logic [NW-1:0] p_m = '0;
   logic [DW-1:0] p_d = '0;
   logic [DW-1:0] e_d0 = '0, e_d1a = '0, e_d1b = '0;
   logic          e_v0 = 0, e_v1 = 0, e_col = 0, e_busy = 0;

   always @(posedge clk) begin
      logic [DW-1:0] nw;
      if (rst) begin
         e_d0 = '0; e_d1a = '0; e_d1b = '0;
         e_v0 = 0; e_v1 = 0; e_col = 0;
         for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
         busy_cnt = DEPTH;
         p_rd0 = 0; p_wr = 0; p_rd1 = 0;
      end else begin
         e_v0 = 0; e_v1 = 0; e_col = 0;
         nw = mmem[p_a0];
         for (int i = 0; i < NW; i++)
            if (p_m[i]) nw[8*i +: 8] = p_d[8*i +: 8];
         if (p_rd0) begin
            e_d0 = mmem[p_a0];
            e_v0 = 1;
         end
         if (p_rd1) begin
            e_col = p_wr && (p_a0 == p_a1) && (p_m != 0);
            e_d1a = e_col ? nw : mmem[p_a1];
            e_d1b = mmem[p_a1];
            e_v1  = 1;
         end
         if (p_wr) mmem[p_a0] = nw;
         p_rd0 = (busy_cnt == 0) && !csb0 && web0;
         p_wr  = (busy_cnt == 0) && !csb0 && !web0;
         p_rd1 = (busy_cnt == 0) && !csb1;
         p_a0 = addr0; p_a1 = addr1;
         p_m  = wmask0; p_d = din0;
         if (busy_cnt > 0) busy_cnt--;
      end
      e_busy = (busy_cnt > 0);
   end

   // Every-cycle compare of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_d0_a", d0_a, e_d0);
         chk("cmp_d0_b", d0_b, e_d0);
         chk("cmp_d1_a", d1_a, e_d1a);
         chk("cmp_d1_b", d1_b, e_d1b);
         chk("cmp_v0_a", v0_a, e_v0);
         chk("cmp_v0_b", v0_b, e_v0);
         chk("cmp_v1_a", v1_a, e_v1);
         chk("cmp_v1_b", v1_b, e_v1);
         chk("cmp_col_a", col_a, e_col);
         chk("cmp_col_b", col_b, e_col);
         chk("cmp_busy_a", busy_a, e_busy);
         chk("cmp_busy_b", busy_b, e_busy);
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic req(input logic c0, input logic w0,
                      input logic [NW-1:0] m,
                      input logic [AW-1:0] a0,
                      input logic [DW-1:0] d,
                      input logic c1,
                      input logic [AW-1:0] a1);
      csb0 = c0; web0 = w0; wmask0 = m;
      addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
      tick();
   endtask

   task automatic nop();
      csb0 = 1; web0 = 1; csb1 = 1; wmask0 = '0;
      tick();
   endtask

   task automatic wait_clear(input string nm);
      int n = 0;
      while (busy_a === 1'b1 && n < 600) begin
         n++;
         tick();
      end
      chk(nm, n, 512);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      chk("rst_d0", d0_a, 32'h0);
      chk("rst_d1", d1_a, 32'h0);
      chk("rst_v0", v0_a, 1'b0);
      chk("rst_v1", v1_a, 1'b0);
      chk("rst_col", col_a, 1'b0);
      chk("rst_busy", busy_a, 1'b1);
      chk_en = 1'b1;
      rst = 1'b0;
      wait_clear("busy_len1");

      req(1, 1, 4'h0, 9'h000, 32'h0, 0, 9'h1FF);
      nop();
      chk("rd1_1ff", d1_a, 32'h0);
      chk("rd1_1ff_v", v1_a, 1'b1);

      req(0, 0, 4'hF, 9'h010, 32'hDEADBEEF, 1, 9'h0);
      req(0, 1, 4'h0, 9'h010, 32'h0, 1, 9'h0);
      nop();
      chk("rd0_010", d0_a, 32'hDEADBEEF);
      chk("rd0_010_v", v0_a, 1'b1);
      nop();
      chk("rd0_010_v_once", v0_a, 1'b0);
      chk("rd0_010_hold", d0_a, 32'hDEADBEEF);

      req(0, 0, 4'hF, 9'h020, 32'h11223344, 1, 9'h0);
      req(0, 0, 4'h5, 9'h020, 32'hAABBCCDD, 1, 9'h0);
      req(0, 1, 4'h0, 9'h020, 32'h0, 1, 9'h0);
      nop();
      chk("mask_0101", d0_a, 32'h11BB33DD);

      req(0, 0, 4'hF, 9'h005, 32'hCAFEF00D, 0, 9'h005);
      nop();
      chk("coll_flag", col_a, 1'b1);
      chk("coll_byp", d1_a, 32'hCAFEF00D);
      chk("coll_nobyp", d1_b, 32'h00000000);

      req(0, 0, 4'h3, 9'h006, 32'h12345678, 0, 9'h006);
      nop();
      chk("coll_part_byp", d1_a, 32'h00005678);
      chk("coll_part_nobyp", d1_b, 32'h00000000);

      req(0, 0, 4'h0, 9'h005, 32'hFFFFFFFF, 0, 9'h005);
      nop();
      chk("zmask_col", col_a, 1'b0);
      chk("zmask_d1", d1_a, 32'hCAFEF00D);

      req(0, 1, 4'h0, 9'h010, 32'h0, 0, 9'h010);
      nop();
      chk("rr_d0", d0_a, 32'hDEADBEEF);
      chk("rr_d1", d1_a, 32'hDEADBEEF);
      chk("rr_col", col_a, 1'b0);

      for (int i = 0; i < 8; i++)
         req(0, 0, 4'hF, AW'(9'h040 + i),
             {4{8'(i + 1)}}, 1, 9'h0);
      for (int i = 0; i < 8; i++)
         req(0, 1, 4'h0, AW'(9'h040 + i), 32'h0,
             0, AW'(9'h047 - i));
      nop();
      chk("stream_last0", d0_a, 32'h08080808);
      chk("stream_last1", d1_a, 32'h01010101);

      req(0, 0, 4'hF, 9'h000, 32'h55AA55AA, 1, 9'h0);
      req(0, 1, 4'h0, 9'h000, 32'h0, 1, 9'h0);
      nop();
      chk("pre_clr_000", d0_a, 32'h55AA55AA);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (49) tick();
      req(0, 1, 4'h0, 9'h010, 32'h0, 1, 9'h0);
      nop();
      chk("drop_v0", v0_a, 1'b0);
      chk("drop_d0", d0_a, 32'h0);
      repeat (49) tick();
      chk("mid_busy", busy_a, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("restart_busy", busy_a, 1'b1);
      wait_clear("busy_len2");

      req(0, 1, 4'h0, 9'h000, 32'h0, 1, 9'h0);
      nop();
      chk("post_clr_000", d0_a, 32'h0);
      chk("post_clr_v0", v0_a, 1'b1);
      nop();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
